ram_bank: RTL and testbench

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank.sv | 142 ++++++++++++++
 tb/tb_ram_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank.sv
// Single-port-write / single-port-read RAM bank with byte enables, a zeroing sweep
// after reset or on request, and a configurable 1- or 2-cycle registered read path.
module ram_bank #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_req,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_clr_we;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [DATA_WIDTH-1:0]   w_be_mask;
  logic [DATA_WIDTH-1:0]   w_wr_word;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  logic                    r_vld1;
  logic [DATA_WIDTH-1:0]   r_d1;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_bank: READ_LATENCY must be 1 or 2");
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_state_nxt;
  end

  // Next state: sweep ends on the edge writing the last word; clr_req always restarts it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (!clr_req && r_cnt == LAST_ADDR) w_state_nxt = S_READY;
      S_READY: if (clr_req) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Per-state strobes; a read coincident with clr_req would be flushed, so it is never accepted
  always_comb begin
    w_clr_we = 1'b0;
    w_wr_acc = 1'b0;
    w_rd_acc = 1'b0;
    case (r_state)
      S_CLEAR: w_clr_we = 1'b1;
      S_READY: begin
        w_wr_acc = wr_en;
        w_rd_acc = rd_en && !clr_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (clr_req)  r_cnt <= '0;
    else if (w_clr_we) r_cnt <= r_cnt + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= 1'b1;
    else        r_busy <= (w_state_nxt == S_CLEAR);
  end

  assign busy = r_busy;

  for (genvar b = 0; b < NBYTES; b++) begin : g_mask
    assign w_be_mask[8*b +: 8] = {8{wr_be[b]}};
  end

  assign w_wr_word = (r_mem[wr_addr] & ~w_be_mask) | (wr_data & w_be_mask);
  assign w_rd_word = ((RDW_MODE != 0) && w_wr_acc && (wr_addr == rd_addr)) ? w_wr_word
                                                                          : r_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (w_clr_we)      r_mem[r_cnt]   <= '0;
    else if (w_wr_acc) r_mem[wr_addr] <= w_wr_word;
  end

  // First read stage; data only loads on an accepted read so it holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1 <= 1'b0;
      r_d1   <= '0;
    end else begin
      r_vld1 <= w_rd_acc;
      if (w_rd_acc) r_d1 <= w_rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_d2;

    // Output stage; a clear request kills the read still sitting in stage one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld2 <= 1'b0;
        r_d2   <= '0;
      end else begin
        r_vld2 <= r_vld1 && !clr_req;
        if (r_vld1 && !clr_req) r_d2 <= r_d1;
      end
    end

    assign rd_valid = r_vld2;
    assign rd_data  = r_d2;
  end else begin : g_lat1
    assign rd_valid = r_vld1;
    assign rd_data  = r_d1;
  end

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: two instances (latency 1 / old-data and latency 2 / new-data)
// share stimulus; a scoreboard checks read data and exact read latency per instance.
module tb_ram_bank;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;

  typedef struct {
    logic [31:0] data;
    int          t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .busy(busy_a)
  );

  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else             n_pass++;
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest outstanding read, at its exact cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid_a) begin
        if (qa.size() == 0) check("a_unexpected_valid", 32'(rd_valid_a), 32'd0);
        else begin
          ea = qa.pop_front();
          check("a_rd_data", rd_data_a, ea.data);
          check("a_rd_latency", 32'(cyc), 32'(ea.t + 1));
        end
      end
      if (rd_valid_b) begin
        if (qb.size() == 0) check("b_unexpected_valid", 32'(rd_valid_b), 32'd0);
        else begin
          eb = qb.pop_front();
          check("b_rd_data", rd_data_b, eb.data);
          check("b_rd_latency", 32'(cyc), 32'(eb.t + 2));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_issue(input logic [3:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b);
    rd_en   = 1'b1;
    rd_addr = a;
    qa.push_back('{data: exp_a, t: cyc});
    qb.push_back('{data: exp_b, t: cyc});
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy_a && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'd16);
    check({tag, "_b"}, 32'(busy_b), 32'd0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) begin
      rd_issue(4'(i), 32'h0, 32'h0);
      step();
    end
    rd_en = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();

    check("rst_busy_a", 32'(busy_a), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd1);
    check("rst_valid_a", 32'(rd_valid_a), 32'd0);
    check("rst_valid_b", 32'(rd_valid_b), 32'd0);
    check("rst_data_a", rd_data_a, 32'h0);
    check("rst_data_b", rd_data_b, 32'h0);

    rst_n = 1'b1;
    count_busy("init_sweep_len");
    read_all_zero();

    // Byte-enable merge and output hold
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd_issue(4'd3, 32'hDE22BE44, 32'hDE22BE44);
    step();
    rd_en = 1'b0;
    step();
    check("a_hold_valid", 32'(rd_valid_a), 32'd0);
    check("a_hold_data", rd_data_a, 32'hDE22BE44);
    step();
    check("b_hold_valid", 32'(rd_valid_b), 32'd0);
    check("b_hold_data", rd_data_b, 32'hDE22BE44);

    // Back-to-back reads, latency checked by the scoreboard
    wr(4'd0, 32'hA0A0A0A0, 4'hF);
    wr(4'd1, 32'hA1A1A1A1, 4'hF);
    wr(4'd2, 32'hA2A2A2A2, 4'hF);
    rd_issue(4'd0, 32'hA0A0A0A0, 32'hA0A0A0A0); step();
    rd_issue(4'd1, 32'hA1A1A1A1, 32'hA1A1A1A1); step();
    rd_issue(4'd2, 32'hA2A2A2A2, 32'hA2A2A2A2); step();
    rd_en = 1'b0;
    repeat (3) step();

    // Read-during-write collisions
    wr(4'd5, 32'hAAAA5555, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_issue(4'd5, 32'hAAAA5555, 32'h12345678);
    step();
    wr_addr = 4'd5; wr_data = 32'hCAFEBABE; wr_be = 4'b0011;
    rd_issue(4'd5, 32'h12345678, 32'h1234BABE);
    step();
    wr_addr = 4'd6; wr_data = 32'h00000066; wr_be = 4'hF;
    rd_issue(4'd3, 32'hDE22BE44, 32'hDE22BE44);
    step();
    wr_en = 1'b0;
    rd_issue(4'd5, 32'h1234BABE, 32'h1234BABE); step();
    rd_issue(4'd6, 32'h00000066, 32'h00000066); step();
    rd_en = 1'b0;
    repeat (3) step();

    // Clear one cycle after a read accept: latency-2 read is flushed, busy ignores traffic
    rd_en = 1'b1; rd_addr = 4'd3;
    qa.push_back('{data: 32'hDE22BE44, t: cyc});
    step();
    rd_en = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("flush_valid_b", 32'(rd_valid_b), 32'd0);
    check("clr_busy_a", 32'(busy_a), 32'd1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd0;
    count_busy("clr_sweep_len");
    wr_en = 1'b0; rd_en = 1'b0;
    read_all_zero();

    // Reset mid-sweep at counter 7
    wr(4'd9, 32'h5A5A5A5A, 4'hF);
    rd_issue(4'd9, 32'h5A5A5A5A, 32'h5A5A5A5A); step();
    rd_en = 1'b0;
    repeat (3) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_a", 32'(rd_valid_a), 32'd0);
    check("mid_rst_valid_b", 32'(rd_valid_b), 32'd0);
    check("mid_rst_data_a", rd_data_a, 32'h0);
    check("mid_rst_data_b", rd_data_b, 32'h0);
    check("mid_rst_busy_a", 32'(busy_a), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    count_busy("rst_sweep_len");
    rd_issue(4'd0, 32'h0, 32'h0); step();
    rd_issue(4'd9, 32'h0, 32'h0); step();
    rd_en = 1'b0;
    repeat (4) step();

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
